id_stage: RTL

- Instruction-decode stage of the 5-stage RV32I pipeline, between the IF/ID register and the ID/EX register.
- Holds the 32x32 architectural register file, written from WB.
- Generates immediates and the main control bundle, and detects load-use hazards.
- Produces every *_ID input of the ID/EX register, plus the stall controls for IF and the PC.

---
 rtl/id_stage.sv | 98 +++++++++
 1 files changed

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with register file, immediate generation,
// control decode and load-use hazard detection.
module id_stage #(
   parameter int XLEN              = 32,
   parameter bit CLEAR_RF_ON_RESET = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     INSTR_ID,
   input  logic [XLEN-1:0] PC_IF_ID,
   input  logic            RegWrite_WB,
   input  logic [4:0]      RD_WB,
   input  logic [XLEN-1:0] WDATA_WB,
   input  logic            MemRead_EX,
   input  logic [4:0]      RD_EX_IN,
   input  logic            Flush_ID,
   output logic [XLEN-1:0] IMM_ID,
   output logic [XLEN-1:0] REG_DATA1_ID,
   output logic [XLEN-1:0] REG_DATA2_ID,
   output logic [XLEN-1:0] PC_ID,
   output logic [2:0]      FUNCT3_ID,
   output logic [6:0]      FUNCT7_ID,
   output logic [4:0]      RD_ID,
   output logic [4:0]      RS1_ID,
   output logic [4:0]      RS2_ID,
   output logic            RegWrite_ID,
   output logic            MemtoReg_ID,
   output logic            MemRead_ID,
   output logic            MemWrite_ID,
   output logic            ALUSrc_ID,
   output logic            Branch_ID,
   output logic [1:0]      ALUop_ID,
   output logic            PCWrite,
   output logic            IF_ID_Write
);
   logic [XLEN-1:0] r_rf [32];
   logic            w_wr;
   logic            w_known;
   logic            w_uses_rs2;
   logic            w_hazard;
   logic            w_kill;
   logic [7:0]      w_ctrl;
   logic [XLEN-1:0] w_imm_i;
   logic [XLEN-1:0] w_imm_s;
   logic [XLEN-1:0] w_imm_b;

   assign w_wr = RegWrite_WB && RD_WB != 5'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         if (CLEAR_RF_ON_RESET)
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      end else if (w_wr)
         r_rf[RD_WB] <= WDATA_WB;
   end

   assign PC_ID     = PC_IF_ID;
   assign FUNCT3_ID = INSTR_ID[14:12];
   assign FUNCT7_ID = INSTR_ID[31:25];
   assign RD_ID     = INSTR_ID[11:7];
   assign RS1_ID    = INSTR_ID[19:15];
   assign RS2_ID    = INSTR_ID[24:20];

   // x0 is forced to zero on read so it never depends on RF reset
   assign REG_DATA1_ID = (RS1_ID == 5'd0) ? '0 : (w_wr && RD_WB == RS1_ID) ? WDATA_WB : r_rf[RS1_ID];
   assign REG_DATA2_ID = (RS2_ID == 5'd0) ? '0 : (w_wr && RD_WB == RS2_ID) ? WDATA_WB : r_rf[RS2_ID];

   assign w_imm_i = {{(XLEN-12){INSTR_ID[31]}}, INSTR_ID[31:20]};
   assign w_imm_s = {{(XLEN-12){INSTR_ID[31]}}, INSTR_ID[31:25], INSTR_ID[11:7]};
   assign w_imm_b = {{(XLEN-12){INSTR_ID[31]}}, INSTR_ID[7], INSTR_ID[30:25], INSTR_ID[11:8], 1'b0};

   // ctrl = {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, Branch, ALUop}
   always_comb begin
      w_ctrl     = 8'b0;
      w_known    = 1'b1;
      w_uses_rs2 = 1'b0;
      IMM_ID     = '0;
      case (INSTR_ID[6:0])
         7'b0110011: begin w_ctrl = 8'b1000_0010; w_uses_rs2 = 1'b1; end
         7'b0010011: begin w_ctrl = 8'b1000_1011; IMM_ID = w_imm_i; end
         7'b0000011: begin w_ctrl = 8'b1110_1000; IMM_ID = w_imm_i; end
         7'b0100011: begin w_ctrl = 8'b0001_1000; IMM_ID = w_imm_s; w_uses_rs2 = 1'b1; end
         7'b1100011: begin w_ctrl = 8'b0000_0101; IMM_ID = w_imm_b; w_uses_rs2 = 1'b1; end
         default:    w_known = 1'b0;
      endcase
   end

   assign w_hazard = MemRead_EX && RD_EX_IN != 5'd0 && w_known &&
                     (RD_EX_IN == RS1_ID || (w_uses_rs2 && RD_EX_IN == RS2_ID));
   assign w_kill   = reset || Flush_ID || w_hazard;

   assign {RegWrite_ID, MemtoReg_ID, MemRead_ID, MemWrite_ID, ALUSrc_ID, Branch_ID, ALUop_ID} =
          w_kill ? 8'b0 : w_ctrl;

   // a flush redirects the PC, so it must win over a load-use stall
   assign PCWrite     = reset || Flush_ID || !w_hazard;
   assign IF_ID_Write = PCWrite;
endmodule
